// File: rtl/counter_sweep_pkg.sv
// Shared constants for the counter sweep sequencer: state encoding and default widths.
// The optional hi-limit dwell is enabled by defining COUNTER_SWEEP_DWELL_EN.
package counter_sweep_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_CLR   = 3'd1;
  localparam logic [ST_W-1:0] ST_UP    = 3'd2;
  localparam logic [ST_W-1:0] ST_DWELL = 3'd3;
  localparam logic [ST_W-1:0] ST_DOWN  = 3'd4;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_NSW_W = 4;
  localparam int DEF_DWELL = 3;

endpackage

// File: rtl/counter_sweep_ctrl_if.sv
// Host + counter signal bundle for the sweep sequencer.
// slave = the sequencer, master = host/counter side.
interface counter_sweep_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int NSW_W = 4
) ();
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] hi_lim;
  logic [WIDTH-1:0] lo_lim;
  logic [NSW_W-1:0] n_sweeps;
  logic [WIDTH-1:0] count;
  logic             enable;
  logic             count_dir;
  logic             ctr_reset;
  logic             busy;
  logic             done;
  logic             err;
  logic [NSW_W-1:0] sweep_cnt;

  modport slave (
    input  start, abort, hi_lim, lo_lim, n_sweeps, count,
    output enable, count_dir, ctr_reset, busy, done, err, sweep_cnt
  );

  modport master (
    output start, abort, hi_lim, lo_lim, n_sweeps, count,
    input  enable, count_dir, ctr_reset, busy, done, err, sweep_cnt
  );
endinterface

// File: rtl/counter4bit.sv
// Up/down counter driven by the sweep sequencer. Cleared only by the synchronous ctr_reset
// so that a system reset of the sequencer leaves the count where it was.
module counter4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             ctr_reset_i,
  input  logic             enable_i,
  input  logic             count_dir_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (ctr_reset_i)    count_d = '0;
    else if (enable_i)  count_d = count_dir_i ? count_q + 1'b1 : count_q - 1'b1;
  end

  always_ff @(posedge clk) count_q <= count_d;

  assign count_o = count_q;

endmodule

// File: rtl/counter_sweep_ctrl_dwell_timer.sv
// Loadable down-counter that times the hold at hi_lim; expired is high once it reaches zero.
// Only instantiated when COUNTER_SWEEP_DWELL_EN is defined.
module sweep_dwell_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)           cnt_d = load_val_i;
    else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Triangle-sweep sequencer: clears the counter, ramps to hi_lim, then bounces hi<->lo n times.
// Define COUNTER_SWEEP_DWELL_EN to hold DWELL extra cycles at hi_lim on every turn.
module counter_sweep_ctrl
  import counter_sweep_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NSW_W = DEF_NSW_W,
  parameter int DWELL = DEF_DWELL
) (
  input  logic             clk,
  input  logic             reset,
  counter_sweep_ctrl_if.slave bus
);

  logic [ST_W-1:0]  state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [NSW_W-1:0] nsw_q, nsw_d, sweep_q, sweep_d, sweep_inc;
  logic             done_q, done_d, err_q, err_d;
  logic             enable_c, dir_c, ctr_rst_c;

`ifdef COUNTER_SWEEP_DWELL_EN
  localparam int DW_W = (DWELL < 2) ? 1 : $clog2(DWELL + 1);
  logic dwell_load, dwell_expired;

  sweep_dwell_timer #(.W(DW_W)) u_dwell (
    .clk        (clk),
    .reset      (reset),
    .load_i     (dwell_load),
    .load_val_i (DW_W'(DWELL - 1)),
    .expired_o  (dwell_expired)
  );
`endif

  assign sweep_inc = sweep_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    nsw_d     = nsw_q;
    sweep_d   = sweep_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    enable_c  = 1'b0;
    dir_c     = 1'b1;
    ctr_rst_c = 1'b0;
`ifdef COUNTER_SWEEP_DWELL_EN
    dwell_load = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if ((bus.lo_lim < bus.hi_lim) && (bus.n_sweeps != '0)) begin
            hi_d    = bus.hi_lim;
            lo_d    = bus.lo_lim;
            nsw_d   = bus.n_sweeps;
            sweep_d = '0;
            state_d = ST_CLR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_CLR: begin
        ctr_rst_c = 1'b1;
        state_d   = ST_UP;
      end
      ST_UP: begin
        // enable is decoded from live count so the counter stops exactly on the limit
        enable_c = (bus.count != hi_q);
        if (bus.count == hi_q) begin
`ifdef COUNTER_SWEEP_DWELL_EN
          dwell_load = 1'b1;
          state_d    = ST_DWELL;
`else
          state_d    = ST_DOWN;
`endif
        end
      end
`ifdef COUNTER_SWEEP_DWELL_EN
      ST_DWELL: begin
        if (dwell_expired) state_d = ST_DOWN;
      end
`endif
      ST_DOWN: begin
        dir_c    = 1'b0;
        enable_c = (bus.count != lo_q);
        if (bus.count == lo_q) begin
          if (sweep_q != nsw_q) sweep_d = sweep_inc;
          if ((sweep_inc == nsw_q) || (sweep_q == nsw_q)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_UP;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.abort && (state_q != ST_IDLE)) begin
      enable_c = 1'b0;
      state_d  = ST_IDLE;
      done_d   = 1'b0;
      sweep_d  = sweep_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      nsw_q   <= '0;
      sweep_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      nsw_q   <= nsw_d;
      sweep_q <= sweep_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.enable    = enable_c;
  assign bus.count_dir = dir_c;
  assign bus.ctr_reset = ctr_rst_c;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.sweep_cnt = sweep_q;

endmodule
